// File: rtl/bus_resp_pkg.sv
// Shared types and defaults for the 68000 bus-cycle responder.
package bus_resp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        EXT  = 3'd2,
        ACK  = 3'd3,
        BERR = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        R_NONE = 3'd0,
        R_ROM  = 3'd1,
        R_RAM  = 3'd2,
        R_IO   = 3'd3,
        R_DRAM = 3'd4,
        R_CAN  = 3'd5
    } region_t;

    localparam int DEF_ROM_WAIT = 1;
    localparam int DEF_RAM_WAIT = 1;
    localparam int DEF_IO_WAIT  = 3;
    localparam int DEF_TIMEOUT  = 255;
    localparam int DEF_CNT_W    = 8;

    // Fixed-priority region pick: ROM > RAM > IO > DRAM > CAN.
    function automatic region_t decode_region(
        input logic rom,
        input logic ram,
        input logic io,
        input logic dram,
        input logic can
    );
        region_t r;
        if (rom)       r = R_ROM;
        else if (ram)  r = R_RAM;
        else if (io)   r = R_IO;
        else if (dram) r = R_DRAM;
        else if (can)  r = R_CAN;
        else           r = R_NONE;
        return r;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Clear/enable counter that flags expiry when it reaches TIMEOUT-1.
// It saturates at TIMEOUT-1 so it can never wrap.
module bus_timeout_counter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic Clk,
    input  logic Reset_H,
    input  logic Clear_H,
    input  logic Enable_H,
    output logic expired_H
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);
    assign expired_H  = Enable_H && w_at_limit;

    // Count clocks while enabled, holding at the limit.
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (Clear_H) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (Enable_H && !w_at_limit) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/bus_response_controller.sv
// 68000 bus-cycle responder: latches the decoded region at cycle start,
// then acknowledges after a fixed wait, forwards an external DTACK, or
// raises a bus error when nobody answers in time.
module bus_response_controller
    import bus_resp_pkg::*;
#(
    parameter int ROM_WAIT = DEF_ROM_WAIT,
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int IO_WAIT  = DEF_IO_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic Clk,
    input  logic Reset_H,
    input  logic AS_L,
    input  logic UDS_L,
    input  logic LDS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic IOSelect_H,
    input  logic DramSelect_H,
    input  logic CanBusSelect_H,
    input  logic DramDtack_L,
    input  logic CanDtack_L,
    output logic DTACK_L,
    output logic BERR_L,
    output logic BusTimeout_H
);

    state_t           r_state, w_state_nxt;
    region_t          r_region, w_region_nxt;
    region_t          w_region_dec;
    logic [CNT_W-1:0] r_wcnt, w_wcnt_nxt;
    logic             r_dtack_l, r_berr_l, r_tout;
    logic             w_dtack_nxt, w_berr_nxt, w_tout_nxt;
    logic             w_ext_dtack_l;
    logic             w_tclr, w_ten, w_expired;
    logic             w_start;

    assign w_start      = !AS_L && (!UDS_L || !LDS_L);
    assign w_region_dec = decode_region(OnChipRomSelect_H, OnChipRamSelect_H,
                                        IOSelect_H, DramSelect_H, CanBusSelect_H);

    // Timeout only runs while waiting on an external responder.
    assign w_ten  = (r_state == EXT);
    assign w_tclr = (r_state == IDLE);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tcnt (
        .Clk       (Clk),
        .Reset_H   (Reset_H),
        .Clear_H   (w_tclr),
        .Enable_H  (w_ten),
        .expired_H (w_expired)
    );

    // Select the external DTACK belonging to the latched region.
    always_comb begin
        w_ext_dtack_l = 1'b1;
        case (r_region)
            R_DRAM:  w_ext_dtack_l = DramDtack_L;
            R_CAN:   w_ext_dtack_l = CanDtack_L;
            default: w_ext_dtack_l = 1'b1;
        endcase
    end

    // Next-state, wait counter and next output values.
    always_comb begin
        w_state_nxt  = r_state;
        w_region_nxt = r_region;
        w_wcnt_nxt   = r_wcnt;
        w_dtack_nxt  = 1'b1;
        w_berr_nxt   = 1'b1;
        w_tout_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_region_nxt = w_region_dec;
                    case (w_region_dec)
                        R_ROM: begin
                            w_state_nxt = WAIT;
                            w_wcnt_nxt  = CNT_W'(ROM_WAIT);
                        end
                        R_RAM: begin
                            w_state_nxt = WAIT;
                            w_wcnt_nxt  = CNT_W'(RAM_WAIT);
                        end
                        R_IO: begin
                            w_state_nxt = WAIT;
                            w_wcnt_nxt  = CNT_W'(IO_WAIT);
                        end
                        default: begin
                            w_state_nxt = EXT;
                            w_wcnt_nxt  = {CNT_W{1'b0}};
                        end
                    endcase
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (AS_L) begin
                    w_state_nxt = IDLE;
                end else if (r_wcnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ACK;
                    w_dtack_nxt = 1'b0;
                end else begin
                    w_wcnt_nxt = r_wcnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            EXT: begin
                if (AS_L) begin
                    w_state_nxt = IDLE;
                end else if (!w_ext_dtack_l) begin
                    // External acknowledge beats a coincident timeout.
                    w_state_nxt = ACK;
                    w_dtack_nxt = 1'b0;
                end else if (w_expired) begin
                    w_state_nxt = BERR;
                    w_berr_nxt  = 1'b0;
                    w_tout_nxt  = 1'b1;
                end else begin
                    w_state_nxt = EXT;
                end
            end
            ACK: begin
                if (AS_L) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_dtack_nxt = 1'b0;
                end
            end
            BERR: begin
                if (AS_L) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_berr_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, latched region, wait counter and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            r_state   <= IDLE;
            r_region  <= R_NONE;
            r_wcnt    <= {CNT_W{1'b0}};
            r_dtack_l <= 1'b1;
            r_berr_l  <= 1'b1;
            r_tout    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_region  <= w_region_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_dtack_l <= w_dtack_nxt;
            r_berr_l  <= w_berr_nxt;
            r_tout    <= w_tout_nxt;
        end
    end

    assign DTACK_L      = r_dtack_l;
    assign BERR_L       = r_berr_l;
    assign BusTimeout_H = r_tout;

endmodule
